hilo_div_seq: RTL

HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

---
 rtl/hilo_div_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/hilo_div_seq.sv
// hilo_div_seq: HI/LO register file sequencing an external divider.
// Handles operand latch, wait with timeout, result write, and exception pulses.
module hilo_div_seq #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [31:0] RegAOut,
   input  logic [31:0] RegBOut,
   input  logic        MtHi,
   input  logic        MtLo,
   input  logic        DivDone,
   input  logic        Div0,
   input  logic [31:0] DivHI,
   input  logic [31:0] DivLO,
   output logic        DivCtrl,
   output logic [31:0] DivA,
   output logic [31:0] DivB,
   output logic [31:0] HIOut,
   output logic [31:0] LOOut,
   output logic        Busy,
   output logic        Done,
   output logic        DivZeroExc,
   output logic        Timeout
);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, EXC} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] diva_q, diva_d, divb_q, divb_d, hi_q, hi_d, lo_q, lo_d;
   logic zero_q, zero_d;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      diva_d  = diva_q;
      divb_d  = divb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE:
            if (Start) begin
               state_d = ISSUE;
               diva_d  = RegAOut;
               divb_d  = RegBOut;
            end else begin
               hi_d = MtHi ? RegAOut : hi_q;
               lo_d = MtLo ? RegAOut : lo_q;
            end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT:
            if (Div0) begin
               state_d = EXC;
               zero_d  = 1'b1;
            end else if (DivDone) begin
               state_d = WRITE;
               hi_d    = DivHI;
               lo_d    = DivLO;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = EXC;
               zero_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         diva_q  <= '0;
         divb_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         diva_q  <= diva_d;
         divb_q  <= divb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         zero_q  <= zero_d;
      end
   end
   // All outputs come from flops or the state decode only.
   assign DivCtrl    = (state_q == ISSUE) || (state_q == WAIT);
   assign Busy       = state_q != IDLE;
   assign Done       = state_q == WRITE;
   assign DivZeroExc = (state_q == EXC) && zero_q;
   assign Timeout    = (state_q == EXC) && !zero_q;
   assign DivA       = diva_q;
   assign DivB       = divb_q;
   assign HIOut      = hi_q;
   assign LOOut      = lo_q;
endmodule
